// File: rtl/pipelined_cpu.sv
`default_nettype none
// ============================================================================
// pipelined_cpu : five-stage in-order 32-bit core (IF/ID/EX/MEM/WB) with
//                 on-chip instruction/data memories and 16-entry register file.
//                 Optional macro FORWARDING_EN enables operand forwarding.
// Revision      : 1.0
// ============================================================================
module pipelined_cpu (
  input  logic clk,
  input  logic rst
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_LOAD  = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_XOR   = 3'b101;
  localparam logic [2:0] OP_STORE = 3'b110;
  localparam logic [2:0] OP_NOP   = 3'b111;

  // Loaded hierarchically; never reset so preloads survive rst.
  logic [31:0] regfile   [0:15];
  logic [31:0] instr_mem [0:255];
  logic [31:0] data_mem  [0:255];

  logic [7:0]  pc_q, pc_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        id_ex_valid_q, id_ex_valid_d;
  logic [2:0]  id_ex_op_q, id_ex_op_d;
  logic [3:0]  id_ex_rs1_q, id_ex_rs1_d;
  logic [3:0]  id_ex_rs2_q, id_ex_rs2_d;
  logic [3:0]  id_ex_rd_q, id_ex_rd_d;
  logic [31:0] id_ex_a_q, id_ex_a_d;
  logic [31:0] id_ex_b_q, id_ex_b_d;
  logic        ex_mem_valid_q, ex_mem_valid_d;
  logic [2:0]  ex_mem_op_q, ex_mem_op_d;
  logic [3:0]  ex_mem_rd_q, ex_mem_rd_d;
  logic [31:0] ex_mem_result_q, ex_mem_result_d;
  logic [31:0] ex_mem_sdata_q, ex_mem_sdata_d;
  logic        mem_wb_valid_q, mem_wb_valid_d;
  logic        mem_wb_we_q, mem_wb_we_d;
  logic [3:0]  mem_wb_rd_q, mem_wb_rd_d;
  logic [31:0] mem_wb_result_q, mem_wb_result_d;

  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        dm_we;
  logic [7:0]  dm_addr;
  logic [2:0]  id_op;
  logic [3:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_a, id_b;
  logic [31:0] ex_a, ex_b, alu_result;
  logic        stall;

  function automatic logic writes_rd(input logic [2:0] op);
    return (op != OP_STORE) && (op != OP_NOP);
  endfunction

  // True when a producer's rd is a source the consumer actually reads.
  function automatic logic src_match(input logic [3:0] rd, input logic [2:0] op,
                                     input logic [3:0] s1, input logic [3:0] s2);
    logic use1, use2;
    use1 = (op != OP_NOP);
    use2 = (op != OP_NOP) && (op != OP_LOAD);
    return (use1 && (rd == s1)) || (use2 && (rd == s2));
  endfunction

  assign rf_we    = rst && mem_wb_valid_q && mem_wb_we_q;
  assign rf_waddr = mem_wb_rd_q;
  assign rf_wdata = mem_wb_result_q;
  assign dm_addr  = ex_mem_result_q[7:0];
  assign dm_we    = rst && ex_mem_valid_q && (ex_mem_op_q == OP_STORE);

  assign id_op  = if_id_instr_q[31:29];
  assign id_rs1 = if_id_instr_q[28:25];
  assign id_rs2 = if_id_instr_q[24:21];
  assign id_rd  = if_id_instr_q[20:17];

  // Write-through: ID sees the value WB is committing this cycle.
  assign id_a = (rf_we && (rf_waddr == id_rs1)) ? rf_wdata : regfile[id_rs1];
  assign id_b = (rf_we && (rf_waddr == id_rs2)) ? rf_wdata : regfile[id_rs2];

`ifdef FORWARDING_EN
  assign stall = if_id_valid_q && id_ex_valid_q && (id_ex_op_q == OP_LOAD) &&
                 src_match(id_ex_rd_q, id_op, id_rs1, id_rs2);
`else
  assign stall = if_id_valid_q &&
                 ((id_ex_valid_q && writes_rd(id_ex_op_q) &&
                   src_match(id_ex_rd_q, id_op, id_rs1, id_rs2)) ||
                  (ex_mem_valid_q && writes_rd(ex_mem_op_q) &&
                   src_match(ex_mem_rd_q, id_op, id_rs1, id_rs2)));
`endif

  always_comb begin
    ex_a = id_ex_a_q;
    ex_b = id_ex_b_q;
`ifdef FORWARDING_EN
    // EX/MEM is checked first so the youngest producer wins.
    if (ex_mem_valid_q && writes_rd(ex_mem_op_q) && (ex_mem_op_q != OP_LOAD) &&
        (ex_mem_rd_q == id_ex_rs1_q))
      ex_a = ex_mem_result_q;
    else if (mem_wb_valid_q && mem_wb_we_q && (mem_wb_rd_q == id_ex_rs1_q))
      ex_a = mem_wb_result_q;
    if (ex_mem_valid_q && writes_rd(ex_mem_op_q) && (ex_mem_op_q != OP_LOAD) &&
        (ex_mem_rd_q == id_ex_rs2_q))
      ex_b = ex_mem_result_q;
    else if (mem_wb_valid_q && mem_wb_we_q && (mem_wb_rd_q == id_ex_rs2_q))
      ex_b = mem_wb_result_q;
`endif
  end

  always_comb begin
    alu_result = ex_a;
    case (id_ex_op_q)
      OP_ADD:  alu_result = ex_a + ex_b;
      OP_SUB:  alu_result = ex_a - ex_b;
      OP_AND:  alu_result = ex_a & ex_b;
      OP_OR:   alu_result = ex_a | ex_b;
      OP_XOR:  alu_result = ex_a ^ ex_b;
      default: alu_result = ex_a;
    endcase
  end

  always_comb begin
    pc_d          = pc_q;
    if_id_valid_d = if_id_valid_q;
    if_id_instr_d = if_id_instr_q;
    if (!stall) begin
      pc_d          = pc_q + 8'd1;
      if_id_valid_d = 1'b1;
      if_id_instr_d = instr_mem[pc_q];
    end

    id_ex_valid_d = if_id_valid_q && !stall;
    id_ex_op_d    = id_op;
    id_ex_rs1_d   = id_rs1;
    id_ex_rs2_d   = id_rs2;
    id_ex_rd_d    = id_rd;
    id_ex_a_d     = id_a;
    id_ex_b_d     = id_b;

    ex_mem_valid_d  = id_ex_valid_q;
    ex_mem_op_d     = id_ex_op_q;
    ex_mem_rd_d     = id_ex_rd_q;
    ex_mem_result_d = alu_result;
    ex_mem_sdata_d  = ex_b;

    mem_wb_valid_d  = ex_mem_valid_q;
    mem_wb_we_d     = writes_rd(ex_mem_op_q);
    mem_wb_rd_d     = ex_mem_rd_q;
    mem_wb_result_d = (ex_mem_op_q == OP_LOAD) ? data_mem[dm_addr] : ex_mem_result_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q            <= '0;
      if_id_valid_q   <= 1'b0;
      if_id_instr_q   <= '0;
      id_ex_valid_q   <= 1'b0;
      id_ex_op_q      <= OP_NOP;
      id_ex_rs1_q     <= '0;
      id_ex_rs2_q     <= '0;
      id_ex_rd_q      <= '0;
      id_ex_a_q       <= '0;
      id_ex_b_q       <= '0;
      ex_mem_valid_q  <= 1'b0;
      ex_mem_op_q     <= OP_NOP;
      ex_mem_rd_q     <= '0;
      ex_mem_result_q <= '0;
      ex_mem_sdata_q  <= '0;
      mem_wb_valid_q  <= 1'b0;
      mem_wb_we_q     <= 1'b0;
      mem_wb_rd_q     <= '0;
      mem_wb_result_q <= '0;
    end else begin
      pc_q            <= pc_d;
      if_id_valid_q   <= if_id_valid_d;
      if_id_instr_q   <= if_id_instr_d;
      id_ex_valid_q   <= id_ex_valid_d;
      id_ex_op_q      <= id_ex_op_d;
      id_ex_rs1_q     <= id_ex_rs1_d;
      id_ex_rs2_q     <= id_ex_rs2_d;
      id_ex_rd_q      <= id_ex_rd_d;
      id_ex_a_q       <= id_ex_a_d;
      id_ex_b_q       <= id_ex_b_d;
      ex_mem_valid_q  <= ex_mem_valid_d;
      ex_mem_op_q     <= ex_mem_op_d;
      ex_mem_rd_q     <= ex_mem_rd_d;
      ex_mem_result_q <= ex_mem_result_d;
      ex_mem_sdata_q  <= ex_mem_sdata_d;
      mem_wb_valid_q  <= mem_wb_valid_d;
      mem_wb_we_q     <= mem_wb_we_d;
      mem_wb_rd_q     <= mem_wb_rd_d;
      mem_wb_result_q <= mem_wb_result_d;
    end
  end

  // Storage arrays have no reset; writes are gated by rst inside rf_we/dm_we.
  always @(posedge clk) begin
    if (rf_we) regfile[rf_waddr] <= rf_wdata;
    if (dm_we) data_mem[dm_addr] <= ex_mem_sdata_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cpu.sv
`default_nettype none
// Scoreboard bench for pipelined_cpu: expected write-backs are queued per
// program and popped by a monitor watching the register-file write port.
module tb_pipelined_cpu;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipelined_cpu dut (.clk(clk), .rst(rst));

`ifdef FORWARDING_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, LOAD = 3'b011;
  localparam logic [2:0] OR_ = 3'b100, XOR_ = 3'b101, STORE = 3'b110;
  localparam logic [31:0] NOP_W = 32'hE000_0000;

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  wb_t e;
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  last_wb = 0;
  int  base_wb;

  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Monitor: each regfile write commits on the following edge (cyc+1).
  always @(negedge clk) begin
    if (!rst) begin
      last_wb = 0;
    end else if (dut.rf_we) begin
      last_wb = cyc + 1;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected: got r%0d=%h, required no write", dut.rf_waddr, dut.rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if (e.rd != dut.rf_waddr || e.data != dut.rf_wdata) begin
          bad++;
          $display("FAIL wb_stream: got r%0d=%h, required r%0d=%h",
                   dut.rf_waddr, dut.rf_wdata, e.rd, e.data);
        end
      end
    end
  end

  function automatic logic [31:0] enc(input logic [2:0] op, input logic [3:0] rs1,
                                      input logic [3:0] rs2, input logic [3:0] rd);
    return {op, rs1, rs2, rd, 17'h0};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic expect_wb(input logic [3:0] rd, input logic [31:0] data);
    exp_q.push_back({rd, data});
  endtask

  // Called with rst low: clears state that tests rely on.
  task automatic clear_all();
    for (int i = 0; i < 16; i++)  dut.regfile[i] = 32'h0;
    for (int i = 0; i < 256; i++) dut.instr_mem[i] = NOP_W;
    for (int i = 0; i < 256; i++) dut.data_mem[i] = 32'h0;
  endtask

  task automatic enter_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic release_and_run(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_chain();
    clear_all();
    dut.regfile[2] = 32'd5;  dut.regfile[4] = 32'd10;
    dut.regfile[6] = 32'd3;  dut.regfile[8] = 32'd15;
    dut.data_mem[5] = 32'd100;
    dut.instr_mem[0] = enc(LOAD, 4'd2, 4'd0, 4'd1);
    dut.instr_mem[1] = enc(ADD,  4'd1, 4'd4, 4'd3);
    dut.instr_mem[2] = enc(SUB,  4'd3, 4'd6, 4'd5);
    dut.instr_mem[3] = enc(AND_, 4'd5, 4'd8, 4'd7);
    expect_wb(4'd1, 32'd100);
    expect_wb(4'd3, 32'd110);
    expect_wb(4'd5, 32'd107);
    expect_wb(4'd7, 32'd11);
  endtask

  task automatic check_chain(input string tag);
    check({tag, "_r1"}, dut.regfile[1], 32'd100);
    check({tag, "_r3"}, dut.regfile[3], 32'd110);
    check({tag, "_r5"}, dut.regfile[5], 32'd107);
    check({tag, "_r7"}, dut.regfile[7], 32'd11);
    check({tag, "_last_wb"}, last_wb, (FWD != 0) ? 32'd9 : 32'd14);
    check({tag, "_q_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    // Reset state
    enter_reset();
    #1;
    check("reset_pc", dut.pc_q, 32'd0);
    check("reset_wb_valid", dut.mem_wb_valid_q, 32'd0);

    // Dependent chain
    load_chain();
    release_and_run((FWD != 0) ? 10 : 20);
    check_chain("chain");

    // Independent baseline then load-use pair
    enter_reset();
    clear_all();
    dut.regfile[2] = 32'd5; dut.regfile[4] = 32'd10; dut.data_mem[5] = 32'd100;
    dut.instr_mem[0] = enc(LOAD, 4'd2, 4'd0, 4'd1);
    dut.instr_mem[1] = enc(ADD,  4'd4, 4'd4, 4'd3);
    expect_wb(4'd1, 32'd100);
    expect_wb(4'd3, 32'd20);
    release_and_run(20);
    check("indep_pair_r3", dut.regfile[3], 32'd20);
    check("indep_pair_last_wb", last_wb, 32'd6);
    base_wb = last_wb;

    enter_reset();
    clear_all();
    dut.regfile[2] = 32'd5; dut.data_mem[5] = 32'd100;
    dut.instr_mem[0] = enc(LOAD, 4'd2, 4'd0, 4'd1);
    dut.instr_mem[1] = enc(ADD,  4'd1, 4'd1, 4'd3);
    expect_wb(4'd1, 32'd100);
    expect_wb(4'd3, 32'd200);
    release_and_run(20);
    check("loaduse_r3", dut.regfile[3], 32'd200);
    check("loaduse_extra_cycles", last_wb - base_wb, (FWD != 0) ? 32'd1 : 32'd2);
    check("loaduse_q_empty", exp_q.size(), 32'd0);

    // Store then load same address
    enter_reset();
    clear_all();
    dut.regfile[2] = 32'd9; dut.regfile[4] = 32'h0000_DEAD;
    dut.instr_mem[0] = enc(STORE, 4'd2, 4'd4, 4'd0);
    dut.instr_mem[1] = enc(LOAD,  4'd2, 4'd0, 4'd5);
    expect_wb(4'd5, 32'h0000_DEAD);
    release_and_run(20);
    check("stld_r5", dut.regfile[5], 32'h0000_DEAD);
    check("stld_mem9", dut.data_mem[9], 32'h0000_DEAD);
    check("stld_r0_untouched", dut.regfile[0], 32'h0);
    check("stld_last_wb", last_wb, 32'd6);

    // Wrap-around arithmetic
    enter_reset();
    clear_all();
    dut.regfile[1] = 32'd0; dut.regfile[2] = 32'd1;
    dut.instr_mem[0] = enc(SUB, 4'd1, 4'd2, 4'd3);
    dut.instr_mem[1] = enc(ADD, 4'd3, 4'd2, 4'd4);
    expect_wb(4'd3, 32'hFFFF_FFFF);
    expect_wb(4'd4, 32'h0);
    release_and_run(20);
    check("wrap_r3", dut.regfile[3], 32'hFFFF_FFFF);
    check("wrap_r4", dut.regfile[4], 32'h0);
    check("wrap_last_wb", last_wb, (FWD != 0) ? 32'd6 : 32'd8);

    // Reset asserted right after ADD is fetched
    enter_reset();
    load_chain();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_pc", dut.pc_q, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_r1_held", dut.regfile[1], 32'h0);
    check("midrst_r3_held", dut.regfile[3], 32'h0);
    check("midrst_q_intact", exp_q.size(), 32'd4);
    release_and_run((FWD != 0) ? 10 : 20);
    check_chain("midrst");

    // Independent stream: six ALU ops, no stalls in either build
    enter_reset();
    clear_all();
    for (int i = 1; i <= 7; i++) dut.regfile[i] = i;
    dut.instr_mem[0] = enc(ADD,  4'd1, 4'd2, 4'd8);
    dut.instr_mem[1] = enc(SUB,  4'd3, 4'd1, 4'd9);
    dut.instr_mem[2] = enc(AND_, 4'd6, 4'd7, 4'd10);
    dut.instr_mem[3] = enc(OR_,  4'd4, 4'd1, 4'd11);
    dut.instr_mem[4] = enc(XOR_, 4'd5, 4'd3, 4'd12);
    dut.instr_mem[5] = enc(ADD,  4'd7, 4'd7, 4'd13);
    expect_wb(4'd8,  32'd3);
    expect_wb(4'd9,  32'd2);
    expect_wb(4'd10, 32'd6);
    expect_wb(4'd11, 32'd5);
    expect_wb(4'd12, 32'd6);
    expect_wb(4'd13, 32'd14);
    release_and_run(12);
    check("indep_r12", dut.regfile[12], 32'd6);
    check("indep_r13", dut.regfile[13], 32'd14);
    check("indep_last_wb", last_wb, 32'd10);
    check("indep_q_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
